// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
//   arb_state_e : arbiter state (IDLE searches round-robin, LOCKED holds one requester)
//   idx_w()     : index width for a given requester count (clog2, minimum 1)
//   req_idx_t   : requester index wide enough for the largest supported NUM_REQ (16)
package obi_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_NUM_REQ = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_IDX_W = idx_w(MAX_NUM_REQ);

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/obi_arb_idx_fifo.sv
// In-order FIFO of requester indices for transactions awaiting their response.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   push_i, din_i   : enqueue the index of a granted transaction
//   pop_i           : dequeue on a response (caller guarantees non-empty)
//   dout_o          : index at the head (owner of the next response)
//   count_o         : number of stored entries (0..DEPTH)
module obi_arb_idx_fifo
  import obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  req_idx_t         din_i,
  output req_idx_t         dout_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_idx_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointer increment that wraps at DEPTH
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers and occupancy; push+pop together leaves count unchanged
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = ptr_inc(wr_q);
    if (pop_i)  rd_d = ptr_inc(rd_q);
    if (push_i && !pop_i)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop_i && !push_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[wr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NUM_REQ requesters.
// A pending-but-ungranted address phase locks the arbiter onto that requester
// so the A-channel stays stable until grant. Up to MAX_OUTST transactions may
// be in flight; responses are routed back in order via an index FIFO.
// Ports:
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   m_*_i / m_gnt_o          : packed per-requester A-channel, one-hot grant
//   m_rvalid_o, m_rdata_o,
//   m_err_o                  : one-hot response valid, broadcast data/error
//   obi_*                    : shared OBI A/R channels (rready tied high)
//   proto_err_o              : sticky protocol error
// Optional: define OBI_ARB_PROTO_CHK_EN to build the protocol checker; otherwise
// proto_err_o is tied to 0.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic [NUM_REQ-1:0]              m_req_i,
  input  logic [NUM_REQ-1:0]              m_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_REQ-1:0]              m_gnt_o,
  output logic [NUM_REQ-1:0]              m_rvalid_o,
  output logic [DATA_WIDTH-1:0]           m_rdata_o,
  output logic                            m_err_o,
  output logic                            obi_req_o,
  input  logic                            obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]           obi_addr_o,
  output logic                            obi_we_o,
  output logic [DATA_WIDTH/8-1:0]         obi_be_o,
  output logic [DATA_WIDTH-1:0]           obi_wdata_o,
  input  logic                            obi_rvalid_i,
  output logic                            obi_rready_o,
  input  logic [DATA_WIDTH-1:0]           obi_rdata_i,
  input  logic                            obi_err_i,
  output logic                            proto_err_o
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] rr_ptr_q, lock_idx_q;
  logic [IDX_W-1:0] rr_idx, cand, sel_idx, rr_next;
  logic             rr_hit, eligible, not_full, handshake, lock_drop, pop;
  logic [CNT_W-1:0] count;
  req_idx_t         head_idx;
  logic             unused_head;

  // Round-robin search: first active request at or above rr_ptr, wrapping
  always_comb begin
    rr_idx = rr_ptr_q;
    rr_hit = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!rr_hit && m_req_i[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // While locked, only the locked requester is considered
  always_comb begin
    sel_idx  = rr_idx;
    eligible = rr_hit;
    if (state_q == LOCKED) begin
      sel_idx  = lock_idx_q;
      eligible = m_req_i[lock_idx_q];
    end
  end

  // Full check uses the registered count: a same-cycle pop frees nothing
  assign not_full  = (count < CNT_W'(MAX_OUTST));
  assign obi_req_o = eligible & not_full;
  assign handshake = obi_req_o & obi_gnt_i;
  assign lock_drop = (state_q == LOCKED) & ~m_req_i[lock_idx_q];
  assign rr_next   = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);

  // A-channel mux, zeroed when no request is presented
  always_comb begin
    obi_addr_o  = '0;
    obi_we_o    = 1'b0;
    obi_be_o    = '0;
    obi_wdata_o = '0;
    if (obi_req_o) begin
      obi_addr_o  = m_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
      obi_we_o    = m_we_i[sel_idx];
      obi_be_o    = m_be_i[sel_idx*BE_W +: BE_W];
      obi_wdata_o = m_wdata_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign m_gnt_o = handshake ? (NUM_REQ'(1) << sel_idx) : '0;

  // Arbitration state, lock index and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      if (handshake) rr_ptr_q <= rr_next;
      case (state_q)
        IDLE: begin
          if (obi_req_o && !obi_gnt_i) begin
            state_q    <= LOCKED;
            lock_idx_q <= sel_idx;
          end
        end
        LOCKED: begin
          if (handshake || lock_drop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses with nothing in flight are dropped
  assign pop = obi_rvalid_i & (count != '0);

  obi_arb_idx_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_idx_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (handshake),
    .pop_i    (pop),
    .din_i    (REQ_IDX_W'(sel_idx)),
    .dout_o   (head_idx),
    .count_o  (count)
  );

  // Stored indices are zero-extended; only the low IDX_W bits matter
  assign unused_head = ^head_idx;

  assign m_rvalid_o   = pop ? (NUM_REQ'(1) << head_idx[IDX_W-1:0]) : '0;
  assign m_rdata_o    = obi_rdata_i;
  assign m_err_o      = obi_err_i;
  assign obi_rready_o = 1'b1;

`ifdef OBI_ARB_PROTO_CHK_EN
  logic proto_err_q;

  // Sticky: unexpected response or locked requester withdrawing early
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      proto_err_q <= 1'b0;
    end else if ((obi_rvalid_i && (count == '0)) || lock_drop) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_obi_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

`ifdef OBI_ARB_PROTO_CHK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    m_req, m_we, m_gnt, m_rvalid;
  logic [N*AW-1:0] m_addr;
  logic [N*BW-1:0] m_be;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic            obi_req, obi_gnt, obi_we, obi_rvalid, obi_rready, obi_err, proto_err;
  logic [AW-1:0]   obi_addr;
  logic [BW-1:0]   obi_be;
  logic [DW-1:0]   obi_wdata, obi_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  obi_rr_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_OUTST  (MO)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .m_req_i      (m_req),
    .m_we_i       (m_we),
    .m_addr_i     (m_addr),
    .m_be_i       (m_be),
    .m_wdata_i    (m_wdata),
    .m_gnt_o      (m_gnt),
    .m_rvalid_o   (m_rvalid),
    .m_rdata_o    (m_rdata),
    .m_err_o      (m_err),
    .obi_req_o    (obi_req),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_o   (obi_addr),
    .obi_we_o     (obi_we),
    .obi_be_o     (obi_be),
    .obi_wdata_o  (obi_wdata),
    .obi_rvalid_i (obi_rvalid),
    .obi_rready_o (obi_rready),
    .obi_rdata_i  (obi_rdata),
    .obi_err_i    (obi_err),
    .proto_err_o  (proto_err)
  );

  // Reference model: next-in-turn pointer, lock, queue of response owners
  int mdl_rr;
  bit mdl_locked;
  int mdl_lock;
  int mdl_q[$];
  bit mdl_perr;

  bit            e_req;
  int            e_sel;
  logic [N-1:0]  e_gnt, e_rvalid;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wdata;

  function automatic void model_reset();
    mdl_rr = 0;
    mdl_locked = 1'b0;
    mdl_lock = 0;
    mdl_q.delete();
    mdl_perr = 1'b0;
  endfunction

  function automatic void model_eval();
    bit elig;
    elig  = 1'b0;
    e_sel = 0;
    if (mdl_locked) begin
      e_sel = mdl_lock;
      elig  = m_req[mdl_lock];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mdl_rr + k) % N;
        if (!elig && m_req[c]) begin
          elig  = 1'b1;
          e_sel = c;
        end
      end
    end
    e_req   = elig && (mdl_q.size() < MO);
    e_gnt   = '0;
    if (e_req && obi_gnt) e_gnt[e_sel] = 1'b1;
    e_addr  = e_req ? m_addr[e_sel*AW +: AW] : '0;
    e_we    = e_req ? m_we[e_sel] : 1'b0;
    e_be    = e_req ? m_be[e_sel*BW +: BW] : '0;
    e_wdata = e_req ? m_wdata[e_sel*DW +: DW] : '0;
    e_rvalid = '0;
    if (obi_rvalid && mdl_q.size() > 0) e_rvalid[mdl_q[0]] = 1'b1;
  endfunction

  // Clock-edge update; uses the results of the preceding model_eval
  function automatic void model_update();
    bit hs;
    hs = e_req && obi_gnt;
    if (obi_rvalid) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      else mdl_perr = 1'b1;
    end
    if (hs) begin
      mdl_q.push_back(e_sel);
      mdl_rr = (e_sel + 1) % N;
      mdl_locked = 1'b0;
    end else if (mdl_locked && !m_req[mdl_lock]) begin
      mdl_locked = 1'b0;
      mdl_perr = 1'b1;
    end else if (!mdl_locked && e_req) begin
      mdl_locked = 1'b1;
      mdl_lock = e_sel;
    end
  endfunction

  task automatic clear_inputs();
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_ni = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_ni = 1'b1;
  endtask

  task automatic step();
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    // Leave a transaction in flight and the arbiter locked before resetting
    m_req = 4'b0100; obi_gnt = 1'b1;
    @(negedge clk); model_eval(); step();
    m_req = 4'b0010; obi_gnt = 1'b0;
    @(negedge clk); model_eval(); step();
    clear_inputs();
    reset_ni = 1'b0;
    model_reset();
    @(negedge clk);
    n_cmp++; if (obi_req !== 1'b0) begin n_err++; $display("FAIL reset_obi_req: got %b want 0", obi_req); end
    n_cmp++; if (m_gnt !== 4'b0000) begin n_err++; $display("FAIL reset_m_gnt: got %b want 0000", m_gnt); end
    n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL reset_m_rvalid: got %b want 0000", m_rvalid); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    n_cmp++; if (obi_rready !== 1'b1) begin n_err++; $display("FAIL reset_rready: got %b want 1", obi_rready); end
    @(posedge clk); #1;
    reset_ni = 1'b1;
    // After release: rr_ptr=0, IDLE, FIFO empty
    m_req = 4'b1111; obi_gnt = 1'b1; obi_rvalid = 1'b1;
    @(negedge clk); model_eval();
    n_cmp++; if (m_gnt !== 4'b0001) begin n_err++; $display("FAIL post_reset_gnt: got %b want 0001", m_gnt); end
    n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL post_reset_rvalid: got %b want 0000", m_rvalid); end
    step();
    obi_rvalid = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    m_req = 4'b0100; m_we = 4'b0100;
    m_addr[2*AW +: AW] = 32'hDEADBEEF; m_be[2*BW +: BW] = 4'hA; m_wdata[2*DW +: DW] = 32'hCAFEF00D;
    m_addr[0 +: AW] = 32'h11111111;
    obi_gnt = 1'b1;
    @(negedge clk); model_eval();
    n_cmp++; if (obi_addr !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_addr: got %h want deadbeef", obi_addr); end
    n_cmp++; if (m_gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", m_gnt); end
    n_cmp++; if ({obi_we, obi_be, obi_wdata} !== {1'b1, 4'hA, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL single_payload: got %b %h %h want 1 a cafef00d", obi_we, obi_be, obi_wdata); end
    step();
    m_req = '0; obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'h12345678;
    @(negedge clk); model_eval();
    n_cmp++; if (m_rvalid !== 4'b0100) begin n_err++; $display("FAIL single_rvalid: got %b want 0100", m_rvalid); end
    n_cmp++; if (m_rdata !== 32'h12345678) begin n_err++; $display("FAIL single_rdata: got %h want 12345678", m_rdata); end
    n_cmp++; if (obi_req !== 1'b0) begin n_err++; $display("FAIL single_idle_req: got %b want 0", obi_req); end
    step();
    obi_rvalid = 1'b0;
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] want;
    apply_reset();
    m_req = 4'b1111; obi_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      obi_rvalid = (c > 0);
      @(negedge clk); model_eval();
      want = 4'b0001 << order[c];
      n_cmp++; if (m_gnt !== want) begin n_err++; $display("FAIL fair_gnt[%0d]: got %b want %b", c, m_gnt, want); end
      if (c > 0) begin
        want = 4'b0001 << order[c-1];
        n_cmp++; if (m_rvalid !== want) begin n_err++; $display("FAIL fair_rvalid[%0d]: got %b want %b", c, m_rvalid, want); end
      end
      step();
    end
    obi_rvalid = 1'b0;
  endtask

  task automatic test_lock();
    apply_reset();
    m_req = 4'b1010;
    m_addr[1*AW +: AW] = 32'hA1A1A1A1; m_addr[3*AW +: AW] = 32'hA3A3A3A3;
    obi_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); model_eval();
      n_cmp++; if (obi_addr !== 32'hA1A1A1A1) begin n_err++; $display("FAIL lock_addr[%0d]: got %h want a1a1a1a1", c, obi_addr); end
      n_cmp++; if (m_gnt !== 4'b0000) begin n_err++; $display("FAIL lock_nogrant[%0d]: got %b want 0000", c, m_gnt); end
      step();
    end
    obi_gnt = 1'b1;
    @(negedge clk); model_eval();
    n_cmp++; if (m_gnt !== 4'b0010) begin n_err++; $display("FAIL lock_gnt1: got %b want 0010", m_gnt); end
    step();
    m_req = 4'b1000;
    @(negedge clk); model_eval();
    n_cmp++; if (m_gnt !== 4'b1000) begin n_err++; $display("FAIL lock_gnt3: got %b want 1000", m_gnt); end
    step();
    m_req = '0; obi_gnt = 1'b0; obi_rvalid = 1'b1;
    @(negedge clk); model_eval();
    n_cmp++; if (m_rvalid !== 4'b0010) begin n_err++; $display("FAIL lock_rvalid1: got %b want 0010", m_rvalid); end
    step();
    @(negedge clk); model_eval();
    n_cmp++; if (m_rvalid !== 4'b1000) begin n_err++; $display("FAIL lock_rvalid3: got %b want 1000", m_rvalid); end
    step();
    obi_rvalid = 1'b0;
  endtask

  task automatic test_full();
    apply_reset();
    m_req = 4'b0111; obi_gnt = 1'b1;
    @(negedge clk); model_eval(); step();
    m_req = 4'b0110;
    @(negedge clk); model_eval(); step();
    m_req = 4'b0100;
    @(negedge clk); model_eval();
    n_cmp++; if (obi_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b want 0", obi_req); end
    step();
    obi_rvalid = 1'b1;
    @(negedge clk); model_eval();
    n_cmp++; if (m_rvalid !== 4'b0001) begin n_err++; $display("FAIL full_rvalid: got %b want 0001", m_rvalid); end
    n_cmp++; if (obi_req !== 1'b0) begin n_err++; $display("FAIL full_pop_same_cycle: got %b want 0", obi_req); end
    step();
    obi_rvalid = 1'b0;
    @(negedge clk); model_eval();
    n_cmp++; if (m_gnt !== 4'b0100) begin n_err++; $display("FAIL full_issue_after_pop: got %b want 0100", m_gnt); end
    step();
  endtask

  task automatic test_unexpected();
    logic want;
    apply_reset();
    obi_rvalid = 1'b1;
    @(negedge clk); model_eval();
    n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL unexp_rvalid: got %b want 0000", m_rvalid); end
    step();
    obi_rvalid = 1'b0;
    want = PROTO_EN;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); model_eval();
      n_cmp++; if (proto_err !== want) begin n_err++; $display("FAIL unexp_sticky[%0d]: got %b want %b", c, proto_err, want); end
      step();
    end
    apply_reset();
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL unexp_cleared: got %b want 0", proto_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock_drop();
    logic want;
    apply_reset();
    m_req = 4'b0001; obi_gnt = 1'b0;
    @(negedge clk); model_eval(); step();
    m_req = 4'b0000;
    @(negedge clk); model_eval();
    n_cmp++; if (obi_req !== 1'b0) begin n_err++; $display("FAIL drop_req: got %b want 0", obi_req); end
    step();
    m_req = 4'b0100; obi_gnt = 1'b1;
    @(negedge clk); model_eval();
    want = PROTO_EN;
    n_cmp++; if (m_gnt !== 4'b0100) begin n_err++; $display("FAIL drop_regrant: got %b want 0100", m_gnt); end
    n_cmp++; if (proto_err !== want) begin n_err++; $display("FAIL drop_proto: got %b want %b", proto_err, want); end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] gprev;
    apply_reset();
    gprev = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_req[i] && !gprev[i]) begin
          if ($urandom_range(0, 15) == 0) m_req[i] = 1'b0;
        end else begin
          m_req[i] = ($urandom_range(0, 2) == 0);
          if (m_req[i]) begin
            m_addr[i*AW +: AW]  = $urandom;
            m_we[i]             = 1'($urandom_range(0, 1));
            m_be[i*BW +: BW]    = BW'($urandom);
            m_wdata[i*DW +: DW] = $urandom;
          end
        end
      end
      obi_gnt    = 1'($urandom_range(0, 1));
      obi_rvalid = ($urandom_range(0, 2) == 0);
      obi_rdata  = $urandom;
      obi_err    = 1'($urandom_range(0, 1));
      @(negedge clk); model_eval();
      n_cmp++; if (obi_req !== e_req) begin n_err++; $display("FAIL rnd_req[%0d]: got %b want %b", c, obi_req, e_req); end
      n_cmp++; if (m_gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, m_gnt, e_gnt); end
      n_cmp++; if (m_rvalid !== e_rvalid) begin n_err++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, m_rvalid, e_rvalid); end
      n_cmp++; if ({obi_addr, obi_we, obi_be, obi_wdata} !== {e_addr, e_we, e_be, e_wdata}) begin
        n_err++; $display("FAIL rnd_achan[%0d]: got %h %b %h %h want %h %b %h %h", c,
                          obi_addr, obi_we, obi_be, obi_wdata, e_addr, e_we, e_be, e_wdata); end
      n_cmp++; if ({m_rdata, m_err} !== {obi_rdata, obi_err}) begin
        n_err++; $display("FAIL rnd_rchan[%0d]: got %h %b want %h %b", c, m_rdata, m_err, obi_rdata, obi_err); end
      n_cmp++; if (proto_err !== (PROTO_EN & mdl_perr)) begin
        n_err++; $display("FAIL rnd_proto[%0d]: got %b want %b", c, proto_err, PROTO_EN & mdl_perr); end
      gprev = e_gnt;
      step();
    end
  endtask

  initial begin
    clear_inputs();
    reset_ni = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_full();
    test_unexpected();
    test_lock_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI manager port between NUM_REQ controller-side requesters using round-robin arbitration.
- Sits between the requesting engines and the OBI A/R channels, in front of the subordinate.
- Holds the address phase stable until grant, as OBI requires.
- Allows up to MAX_OUTST transactions in flight and routes each R-channel response to the requester that issued it, using an in-order index FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTST, 2, maximum number of outstanding granted-but-unanswered transactions (power of 2, at least 1).

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- m_req_i  in  NUM_REQ  per-requester request
- m_we_i  in  NUM_REQ  per-requester write enable
- m_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
- m_be_i  in  NUM_REQ*DATA_WIDTH/8  packed byte enables
- m_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- m_gnt_o  out  NUM_REQ  one-hot grant
- m_rvalid_o  out  NUM_REQ  one-hot response valid
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
- m_err_o  out  1  response error, qualified by m_rvalid_o
- obi_req_o  out  1  A-channel request
- obi_gnt_i  in  1  A-channel grant
- obi_addr_o  out  ADDR_WIDTH  A-channel address
- obi_we_o  out  1  A-channel write enable
- obi_be_o  out  DATA_WIDTH/8  A-channel byte enables
- obi_wdata_o  out  DATA_WIDTH  A-channel write data
- obi_rvalid_i  in  1  R-channel valid
- obi_rready_o  out  1  R-channel ready; tied to 1
- obi_rdata_i  in  DATA_WIDTH  R-channel data
- obi_err_i  in  1  R-channel error
- proto_err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: all state is cleared asynchronously on reset_ni low.
  - State goes to IDLE, rr_ptr to 0, FIFO count to 0.
  - All outputs read 0 except obi_rready_o, which is 1.
  - Any transactions in flight are discarded; responses that arrive after reset count as unexpected.
- FSM states:
  - IDLE: the selected index is the first requester with m_req_i set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - LOCKED: the selected index is lock_idx; all other requesters are ignored.
- Issue condition: obi_req_o = (any eligible request) AND (count < MAX_OUTST).
  - The full check uses the registered count only. A pop in the same cycle does not free a slot for an issue in that cycle.
- A-channel mux: obi_addr_o, obi_we_o, obi_be_o and obi_wdata_o follow the selected slice combinationally. They read 0 when obi_req_o is 0.
- Grant: m_gnt_o[i] = obi_gnt_i AND obi_req_o AND (selected index == i). Latency from m_req_i to obi_req_o is zero cycles.
- FSM transitions:
  - IDLE to LOCKED when obi_req_o=1 and obi_gnt_i=0; lock_idx captures the selected index.
  - LOCKED to IDLE on a handshake.
  - LOCKED to IDLE if m_req_i[lock_idx] drops before grant. This is a violation; no transaction is issued.
- Handshake (obi_req_o and obi_gnt_i both 1):
  - rr_ptr becomes (selected index + 1) mod NUM_REQ.
  - The selected index is pushed into the FIFO.
- Response path:
  - m_rvalid_o[head] = obi_rvalid_i AND (count != 0).
  - m_rdata_o and m_err_o pass through combinationally.
  - A response pops the FIFO head; responses return in order.
- Unexpected response: obi_rvalid_i with an empty FIFO is dropped. No rvalid is asserted and count does not underflow.
- Simultaneous push and pop: count is unchanged, and both FIFO pointers advance and wrap modulo MAX_OUTST.

Optional Feature:
- Macro: OBI_ARB_PROTO_CHK_EN.
- When defined, proto_err_o is set, and held until reset, by either of:
  - an unexpected response (rvalid with an empty FIFO);
  - a locked requester dropping m_req_i before grant.
- When undefined, proto_err_o is tied to 0 and no checker logic is built.

Decomposition:
- Package obi_arb_pkg holds:
  - the state enum (IDLE, LOCKED);
  - an IDX_W constant function equal to clog2 of NUM_REQ, minimum 1;
  - a typedef for the requester index.
- Sub-module obi_arb_idx_fifo holds the index FIFO: depth MAX_OUTST, ports push/pop/din/dout/count, asynchronous active-low reset.
- The round-robin pick stays inline in the arbiter.

Test Plan:
- Reset: with reset_ni=0, obi_req_o=0, m_gnt_o=0, proto_err_o=0 and obi_rready_o=1. After release, state=IDLE and rr_ptr=0.
- Single requester: m_req_i=4'b0100, addr slice 2=0xDEADBEEF, obi_gnt_i=1 in the same cycle.
  - Expect obi_addr_o=0xDEADBEEF and m_gnt_o=4'b0100.
  - Next cycle drive rvalid with rdata=0x12345678; expect m_rvalid_o=4'b0100.
- Fairness: all four requesters held on, obi_gnt_i=1 every cycle, each response returned one cycle after its grant (so count stays under MAX_OUTST).
  - Expect grant order 0,1,2,3,0.
- Lock: requesters 1 and 3 on, obi_gnt_i=0 for 3 cycles.
  - Expect obi_addr_o to stay at slice 1 while requester 3 is ignored.
  - Then gnt=1; expect m_gnt_o=4'b0010, with requester 3 granted next.
- Full: MAX_OUTST=2, two handshakes from requesters 0 and 1 with no rvalid.
  - Expect obi_req_o=0 while requester 2 is pending.
  - Rvalid arrives; expect m_rvalid_o=4'b0001, and requester 2 is issued the following cycle.
- Unexpected rvalid while idle (OBI_ARB_PROTO_CHK_EN defined): expect m_rvalid_o=0 and proto_err_o to go to 1 and stay there until reset.
